// File: rtl/key_conditioner.sv
// Push-button conditioner: polarity fix, 2-flop synchronizer, per-key debounce,
// and registered level, press/release pulses plus an optional auto-repeat train.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_in,
  output logic [N_KEYS-1:0] keys_level,
  output logic [N_KEYS-1:0] keys_press,
  output logic [N_KEYS-1:0] keys_release,
  output logic [N_KEYS-1:0] keys_repeat
);

  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

  logic [N_KEYS-1:0] w_raw;
  logic [N_KEYS-1:0] w_accept;
  logic [N_KEYS-1:0] w_press_evt;
  logic [N_KEYS-1:0] w_release_evt;

  logic [N_KEYS-1:0] r_s1;
  logic [N_KEYS-1:0] r_s2;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [N_KEYS-1:0] r_repeat;
  logic [DW-1:0]     r_cnt   [N_KEYS];
  logic [RW-1:0]     r_rcnt  [N_KEYS];
  rep_state_t        r_state [N_KEYS];

  // Inversion sits ahead of the synchronizer so both flops reset to "not pressed".
  assign w_raw = (KEY_ACTIVE_LOW != 0) ? ~keys_in : keys_in;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_accept[i] = (r_s2[i] != r_level[i]) && (r_cnt[i] == DEB_LAST);
    end
  end

  assign w_press_evt   = w_accept &  r_s2;
  assign w_release_evt = w_accept & ~r_s2;

  // NOTE: sequential state uses non-blocking assignments only; the counter arrays
  // are ordinary flops, not RAM, so they are cleared by reset like everything else.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i]   <= '0;
        r_rcnt[i]  <= '0;
        r_state[i] <= ST_IDLE;
      end
    end else begin
      r_s1      <= w_raw;
      r_s2      <= r_s1;
      r_press   <= w_press_evt;
      r_release <= w_release_evt;

      for (int i = 0; i < N_KEYS; i++) begin
        // Any return to the accepted level restarts the stability count.
        if (r_s2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_level[i] <= r_s2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DW'(1);
        end

        r_repeat[i] <= 1'b0;
        // Release wins over an expiring count on the same edge.
        if ((REPEAT_EN == 0) || w_release_evt[i]) begin
          r_state[i] <= ST_IDLE;
          r_rcnt[i]  <= '0;
        end else begin
          case (r_state[i])
            ST_IDLE: begin
              if (w_press_evt[i]) begin
                r_state[i] <= ST_DELAY;
                r_rcnt[i]  <= '0;
              end
            end
            ST_DELAY: begin
              if (r_rcnt[i] == DLY_LAST) begin
                r_repeat[i] <= 1'b1;
                r_rcnt[i]   <= '0;
                r_state[i]  <= ST_REPEAT;
              end else begin
                r_rcnt[i] <= r_rcnt[i] + RW'(1);
              end
            end
            ST_REPEAT: begin
              if (r_rcnt[i] == PER_LAST) begin
                r_repeat[i] <= 1'b1;
                r_rcnt[i]   <= '0;
              end else begin
                r_rcnt[i] <= r_rcnt[i] + RW'(1);
              end
            end
            default: begin
              r_state[i] <= ST_IDLE;
              r_rcnt[i]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign keys_level   = r_level;
  assign keys_press   = r_press;
  assign keys_release = r_release;
  assign keys_repeat  = r_repeat;

endmodule
